ula_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one combinational `ula` instance between two requesters, for example the execute stage and a multi-cycle helper unit. Each requester presents operands and a 4-bit ALU opcode on a valid/ready request channel. The block latches the winning request, drives the shared ALU for one cycle, and registers the result and zero flag. It then returns them on that requester's valid/ready response channel. Only one operation is in flight at a time.

---
 rtl/ula_arbiter.sv | 143 ++++++++++++++
 tb/tb_ula_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
//==============================================================================
// ula_arbiter : two-port round-robin arbiter sharing one combinational ALU
// Rev 1.0
//==============================================================================
`default_nettype none

module ula_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  // requester 0
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [3:0]       req_op_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_result_0,
  output logic             rsp_zero_0,
  // requester 1
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_op_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result_1,
  output logic             rsp_zero_1,
  // shared ALU
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic winner;
  logic grant_0, grant_1;
  logic owner_rsp_ready;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    grant_0  = 1'b0;
    grant_1  = 1'b0;

    // On a tie the favoured requester wins; otherwise whoever is valid.
    winner          = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
    owner_rsp_ready = owner_q ? rsp_ready_1 : rsp_ready_0;

    case (state_q)
      IDLE: begin
        if (req_valid_0 || req_valid_1) begin
          grant_0 = ~winner;
          grant_1 = winner;
          owner_d = winner;
          a_d     = winner ? req_a_1  : req_a_0;
          b_d     = winner ? req_b_1  : req_b_0;
          op_d    = winner ? req_op_1 : req_op_0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // IDLE is also the reset state, so ready must be masked while reset is held.
  assign req_ready_0  = grant_0 & reset_n;
  assign req_ready_1  = grant_1 & reset_n;

  assign rsp_valid_0  = (state_q == RESP) & ~owner_q;
  assign rsp_valid_1  = (state_q == RESP) &  owner_q;
  assign rsp_result_0 = result_q;
  assign rsp_result_1 = result_q;
  assign rsp_zero_0   = zero_q;
  assign rsp_zero_1   = zero_q;

  assign alu_in1 = a_q;
  assign alu_in2 = b_q;
  assign alu_op  = op_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: vector table of single transactions plus
// hand-written sequences for contention, backpressure, withdrawal and reset.
`default_nettype none

module tb_ula_arbiter;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset_n;
  logic             req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0, rsp_zero_0;
  logic             req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, rsp_zero_1;
  logic [WIDTH-1:0] req_a_0, req_b_0, req_a_1, req_b_1, rsp_result_0, rsp_result_1;
  logic [3:0]       req_op_0, req_op_1;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero, busy;

  int n_checks;
  int n_fail;

  ula_arbiter #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_op_0     (req_op_0),
    .rsp_valid_0  (rsp_valid_0),
    .rsp_ready_0  (rsp_ready_0),
    .rsp_result_0 (rsp_result_0),
    .rsp_zero_0   (rsp_zero_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_op_1     (req_op_1),
    .rsp_valid_1  (rsp_valid_1),
    .rsp_ready_1  (rsp_ready_1),
    .rsp_result_1 (rsp_result_1),
    .rsp_zero_1   (rsp_zero_1),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .busy         (busy)
  );

  // Stand-in for the shared ula: only the opcodes exercised here are modelled.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      4'b1010: alu_result = $signed(alu_in2) >>> alu_in1[4:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
    if (p) begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_op_1 = op;
    end else begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_op_0 = op;
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    drive_req(v.port, 1'b1, v.a, v.b, v.op);
    #1;
    chk("vec_ready_winner", v.port ? req_ready_1 : req_ready_0, 1);
    chk("vec_ready_other",  v.port ? req_ready_0 : req_ready_1, 0);
    tick();
    drive_req(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("vec_exec_busy",    busy, 1);
    chk("vec_exec_ready",   v.port ? req_ready_1 : req_ready_0, 0);
    chk("vec_exec_alu_in1", alu_in1, v.a);
    chk("vec_exec_alu_in2", alu_in2, v.b);
    chk("vec_exec_alu_op",  alu_op, v.op);
    tick();
    chk("vec_rsp_valid",    v.port ? rsp_valid_1 : rsp_valid_0, 1);
    chk("vec_rsp_other",    v.port ? rsp_valid_0 : rsp_valid_1, 0);
    chk("vec_rsp_result",   v.port ? rsp_result_1 : rsp_result_0, v.exp_result);
    chk("vec_rsp_zero",     v.port ? rsp_zero_1 : rsp_zero_0, v.exp_zero);
    if (v.port) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    #1;
    chk("vec_back_idle",    busy, 0);
    chk("vec_rsp_dropped",  v.port ? rsp_valid_1 : rsp_valid_0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{1'b0, 32'd5,        32'd7,          4'b0010, 32'd12,         1'b0};
    vecs[1] = '{1'b1, 32'd3,        32'd4,          4'b0001, 32'd7,          1'b0};
    vecs[2] = '{1'b0, 32'd9,        32'd9,          4'b0110, 32'd0,          1'b1};
    vecs[3] = '{1'b1, 32'd4,        32'h8000_0000,  4'b1010, 32'hF800_0000,  1'b0};
    vecs[4] = '{1'b0, 32'd1,        32'd2,          4'b1111, 32'd0,          1'b1};
    vecs[5] = '{1'b1, 32'h0000_00F0, 32'h0000_003C, 4'b0000, 32'h0000_0030,  1'b0};

    reset_n = 1'b0;
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
    drive_req(1'b1, 1'b1, 32'd1, 32'd1, 4'b0010);

    // Reset state, with requests already pending
    repeat (2) tick();
    chk("rst_req_ready_0", req_ready_0, 0);
    chk("rst_req_ready_1", req_ready_1, 0);
    chk("rst_rsp_valid_0", rsp_valid_0, 0);
    chk("rst_rsp_valid_1", rsp_valid_1, 0);
    chk("rst_busy",        busy, 0);
    chk("rst_alu_in1",     alu_in1, 0);
    chk("rst_rsp_result",  rsp_result_0, 0);

    // Contention: both continuously valid, grants must alternate 0,1,0
    drive_req(1'b0, 1'b1, 32'd9, 32'd9, 4'b0110);
    drive_req(1'b1, 1'b1, 32'd3, 32'd4, 4'b0001);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      int waited;
      waited = 0;
      while (!(req_ready_0 || req_ready_1) && waited < 10) begin
        tick();
        waited++;
      end
      chk("cont_grant_seen",  (req_ready_0 || req_ready_1), 1);
      chk("cont_grant_port",  req_ready_1, k % 2);
      chk("cont_grant_single", req_ready_0 & req_ready_1, 0);
      tick();
      tick();
      chk("cont_rsp_valid",  (k % 2) ? rsp_valid_1 : rsp_valid_0, 1);
      chk("cont_rsp_result", (k % 2) ? rsp_result_1 : rsp_result_0, (k % 2) ? 32'd7 : 32'd0);
      chk("cont_rsp_zero",   (k % 2) ? rsp_zero_1 : rsp_zero_0, (k % 2) ? 0 : 1);
      tick();
      if (k == 2) begin
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    tick();

    // Single-requester vector table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Response backpressure on port 1 while port 0 waits
    drive_req(1'b1, 1'b1, 32'h10, 32'h01, 4'b0001);
    #1;
    chk("bp_ready_1", req_ready_1, 1);
    tick();
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_req(1'b0, 1'b1, 32'd2, 32'd3, 4'b0010);
    #1;
    chk("bp_exec_ready_0", req_ready_0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid_1",  rsp_valid_1, 1);
      chk("bp_rsp_result_1", rsp_result_1, 32'h11);
      chk("bp_busy",         busy, 1);
      chk("bp_ready_0",      req_ready_0, 0);
      chk("bp_rsp_valid_0",  rsp_valid_0, 0);
      tick();
    end
    rsp_ready_1 = 1'b1;
    #1;
    chk("bp_hs_ready_0", req_ready_0, 0);
    tick();
    rsp_ready_1 = 1'b0;
    #1;
    chk("bp_after_ready_0", req_ready_0, 1);
    chk("bp_after_busy",    busy, 0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("bp_p0_rsp_valid",  rsp_valid_0, 1);
    chk("bp_p0_rsp_result", rsp_result_0, 32'd5);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;

    // Withdrawn request on port 1 while busy with port 0
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
    #1;
    chk("wd_ready_0", req_ready_0, 1);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b1, 32'd6, 32'd6, 4'b0010);
    #1;
    chk("wd_exec_ready_1", req_ready_1, 0);
    tick();
    chk("wd_resp_ready_1", req_ready_1, 0);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("wd_no_grant_1", req_ready_1, 0);
      chk("wd_no_rsp_1",   rsp_valid_1, 0);
      chk("wd_idle",       busy, 0);
      tick();
    end

    // Reset in RESP: prio is 1 here (last handshake was owner 0)
    drive_req(1'b0, 1'b1, 32'd7, 32'd8, 4'b0010);
    #1;
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("mr_rsp_valid_0", rsp_valid_0, 1);
    chk("mr_rsp_result",  rsp_result_0, 32'd15);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_rst_rsp_valid_0", rsp_valid_0, 0);
    chk("mr_rst_busy",        busy, 0);
    chk("mr_rst_result",      rsp_result_0, 0);
    chk("mr_rst_alu_in1",     alu_in1, 0);
    chk("mr_rst_alu_op",      alu_op, 0);
    tick();
    reset_n = 1'b1;
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
    drive_req(1'b1, 1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    chk("mr_prio_ready_0", req_ready_0, 1);
    chk("mr_prio_ready_1", req_ready_1, 0);
    chk("mr_no_rsp",       rsp_valid_0, 0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
